gpu_ctrl_axil_slave: RTL and testbench

GPU_CTRL_AXIL_SLAVE -- requirements
Module: gpu_ctrl_axil_slave

---
 rtl/gpu_ctrl_pkg.sv | 50 +++++
 rtl/gpu_ctrl_regfile.sv | 34 +++
 rtl/gpu_ctrl_axil_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_gpu_ctrl_axil_slave.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_ctrl_pkg.sv
// Shared definitions for the GPU control AXI4-Lite register slave:
// widths, register count, response encoding, FSM state types and byte-lane helpers.
package gpu_ctrl_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 4;
  localparam int STRB_W    = DATA_W / 8;
  localparam int REG_COUNT = 4;
  localparam int IDX_W     = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE   = 2'b00,
    W_HAVE_A = 2'b01,
    W_HAVE_D = 2'b10,
    W_RESP   = 2'b11
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [REG_COUNT-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [REG_COUNT-1:0] oh;
    oh      = {REG_COUNT{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/gpu_ctrl_regfile.sv
// Byte-strobed storage for the four GPU control registers plus the read mux.
module gpu_ctrl_regfile
  import gpu_ctrl_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic [IDX_W-1:0]                   wr_idx,
  input  logic [DATA_W-1:0]                  wr_data,
  input  logic [STRB_W-1:0]                  wr_strb,
  input  logic [IDX_W-1:0]                   rd_idx,
  output logic [DATA_W-1:0]                  rd_data,
  output logic [REG_COUNT-1:0][DATA_W-1:0]   regs
);

  logic [REG_COUNT-1:0][DATA_W-1:0] regs_r;

  // Register storage, updated lane by lane on a committed write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_r <= {(REG_COUNT*DATA_W){1'b0}};
    end else if (wr_en) begin
      regs_r[wr_idx] <= merge_bytes(regs_r[wr_idx], wr_data, wr_strb);
    end
  end

  // Read mux sees the pre-write contents during a same-edge write.
  always_comb begin
    rd_data = regs_r[rd_idx];
  end

  assign regs = regs_r;

endmodule

// File: rtl/gpu_ctrl_axil_slave.sv
// AXI4-Lite slave exposing four 32-bit GPU control registers, with
// independent AW/W acceptance, a one-beat read path and per-register write pulses.
module gpu_ctrl_axil_slave
  import gpu_ctrl_pkg::*;
#(
  parameter int C_DATA_WIDTH = DATA_W,
  parameter int C_ADDR_WIDTH = ADDR_W
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [C_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                  s_axi_awprot,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [C_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [C_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                  s_axi_arprot,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [C_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic [DATA_W-1:0]           gpu_reg0,
  output logic [DATA_W-1:0]           gpu_reg1,
  output logic [DATA_W-1:0]           gpu_reg2,
  output logic [DATA_W-1:0]           gpu_reg3,
  output logic [REG_COUNT-1:0]        gpu_wr_pulse
);

  wr_state_e                         wr_state_r, wr_state_s;
  rd_state_e                         rd_state_r, rd_state_s;
  logic                              awready_r, awready_s;
  logic                              wready_r, wready_s;
  logic                              bvalid_r, bvalid_s;
  logic [REG_COUNT-1:0]              wr_pulse_r, wr_pulse_s;
  logic                              arready_r, arready_s;
  logic                              rvalid_r, rvalid_s;
  logic [DATA_W-1:0]                 rdata_r;
  logic [IDX_W-1:0]                  aw_idx_hold_r;
  logic [DATA_W-1:0]                 wdata_hold_r;
  logic [STRB_W-1:0]                 wstrb_hold_r;
  logic                              aw_hs_s, w_hs_s, ar_hs_s;
  logic                              wr_en_s;
  logic [IDX_W-1:0]                  wr_idx_s;
  logic [DATA_W-1:0]                 wr_data_s;
  logic [STRB_W-1:0]                 wr_strb_s;
  logic [DATA_W-1:0]                 rd_data_s;
  logic [REG_COUNT-1:0][DATA_W-1:0]  regs_s;
  logic                              unused_s;

  // Sub-word address bits and protection attributes carry no meaning here.
  assign unused_s = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign aw_hs_s = s_axi_awvalid & awready_r;
  assign w_hs_s  = s_axi_wvalid & wready_r;
  assign ar_hs_s = s_axi_arvalid & arready_r;

  // Write FSM state register and its registered channel outputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_r <= W_IDLE;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      wr_pulse_r <= {REG_COUNT{1'b0}};
    end else begin
      wr_state_r <= wr_state_s;
      awready_r  <= awready_s;
      wready_r   <= wready_s;
      bvalid_r   <= bvalid_s;
      wr_pulse_r <= wr_pulse_s;
    end
  end

  // Write FSM next-state logic.
  always_comb begin
    wr_state_s = wr_state_r;
    case (wr_state_r)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          wr_state_s = W_RESP;
        end else if (aw_hs_s) begin
          wr_state_s = W_HAVE_A;
        end else if (w_hs_s) begin
          wr_state_s = W_HAVE_D;
        end else begin
          wr_state_s = W_IDLE;
        end
      end
      W_HAVE_A: begin
        if (w_hs_s) begin
          wr_state_s = W_RESP;
        end else begin
          wr_state_s = W_HAVE_A;
        end
      end
      W_HAVE_D: begin
        if (aw_hs_s) begin
          wr_state_s = W_RESP;
        end else begin
          wr_state_s = W_HAVE_D;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          wr_state_s = W_IDLE;
        end else begin
          wr_state_s = W_RESP;
        end
      end
      default: wr_state_s = W_IDLE;
    endcase
  end

  // Write FSM outputs, computed from the next state so they register cleanly.
  always_comb begin
    awready_s  = (wr_state_s == W_IDLE) || (wr_state_s == W_HAVE_D);
    wready_s   = (wr_state_s == W_IDLE) || (wr_state_s == W_HAVE_A);
    bvalid_s   = (wr_state_s == W_RESP);
    wr_en_s    = (wr_state_r != W_RESP) && (wr_state_s == W_RESP);
    wr_idx_s   = aw_hs_s ? s_axi_awaddr[3:2] : aw_idx_hold_r;
    wr_data_s  = w_hs_s ? s_axi_wdata : wdata_hold_r;
    wr_strb_s  = w_hs_s ? s_axi_wstrb : wstrb_hold_r;
    wr_pulse_s = wr_en_s ? idx_onehot(wr_idx_s) : {REG_COUNT{1'b0}};
  end

  // Holding registers for whichever write half arrives first.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_idx_hold_r <= {IDX_W{1'b0}};
      wdata_hold_r  <= {DATA_W{1'b0}};
      wstrb_hold_r  <= {STRB_W{1'b0}};
    end else begin
      if (aw_hs_s) begin
        aw_idx_hold_r <= s_axi_awaddr[3:2];
      end
      if (w_hs_s) begin
        wdata_hold_r <= s_axi_wdata;
        wstrb_hold_r <= s_axi_wstrb;
      end
    end
  end

  // Read FSM state register, registered outputs and captured read data.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_r <= R_IDLE;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= {DATA_W{1'b0}};
    end else begin
      rd_state_r <= rd_state_s;
      arready_r  <= arready_s;
      rvalid_r   <= rvalid_s;
      if (ar_hs_s) begin
        rdata_r <= rd_data_s;
      end
    end
  end

  // Read FSM next-state logic.
  always_comb begin
    rd_state_s = rd_state_r;
    case (rd_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          rd_state_s = R_DATA;
        end else begin
          rd_state_s = R_IDLE;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          rd_state_s = R_IDLE;
        end else begin
          rd_state_s = R_DATA;
        end
      end
      default: rd_state_s = R_IDLE;
    endcase
  end

  // Read FSM outputs from the next state.
  always_comb begin
    arready_s = (rd_state_s == R_IDLE);
    rvalid_s  = (rd_state_s == R_DATA);
  end

  gpu_ctrl_regfile u_regfile (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .wr_en   (wr_en_s),
    .wr_idx  (wr_idx_s),
    .wr_data (wr_data_s),
    .wr_strb (wr_strb_s),
    .rd_idx  (s_axi_araddr[3:2]),
    .rd_data (rd_data_s),
    .regs    (regs_s)
  );

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = RESP_OKAY;
  assign gpu_wr_pulse  = wr_pulse_r;
  assign gpu_reg0      = regs_s[0];
  assign gpu_reg1      = regs_s[1];
  assign gpu_reg2      = regs_s[2];
  assign gpu_reg3      = regs_s[3];

endmodule

// File: tb/tb_gpu_ctrl_axil_slave.sv
// Scoreboard bench for gpu_ctrl_axil_slave: expected responses are queued as
// transactions are issued and checked when the slave returns them.
module tb_gpu_ctrl_axil_slave;

  logic        clk;
  logic        rst_n;
  logic [3:0]  s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] gpu_reg0, gpu_reg1, gpu_reg2, gpu_reg3;
  logic [3:0]  gpu_wr_pulse;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [1:0]  b_q[$];
  logic [31:0] r_q[$];
  logic [31:0] model [4];
  int          pulse_cnt = 0;
  logic [3:0]  pulse_seen = 4'b0;

  gpu_ctrl_axil_slave dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .gpu_reg0      (gpu_reg0),
    .gpu_reg1      (gpu_reg1),
    .gpu_reg2      (gpu_reg2),
    .gpu_reg3      (gpu_reg3),
    .gpu_wr_pulse  (gpu_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count the cycles in which any write pulse is high.
  always @(negedge clk) begin
    if (gpu_wr_pulse != 4'b0) begin
      pulse_cnt  = pulse_cnt + 1;
      pulse_seen = pulse_seen | gpu_wr_pulse;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk_eq({tag, "_awready"}, 32'(s_axi_awready), 32'h0);
    chk_eq({tag, "_wready"},  32'(s_axi_wready),  32'h0);
    chk_eq({tag, "_arready"}, 32'(s_axi_arready), 32'h0);
    chk_eq({tag, "_bvalid"},  32'(s_axi_bvalid),  32'h0);
    chk_eq({tag, "_rvalid"},  32'(s_axi_rvalid),  32'h0);
    chk_eq({tag, "_rdata"},   s_axi_rdata,        32'h0);
    chk_eq({tag, "_resp"},    32'({s_axi_bresp, s_axi_rresp}), 32'h0);
    chk_eq({tag, "_pulse"},   32'(gpu_wr_pulse),  32'h0);
    chk_eq({tag, "_regs"},    gpu_reg0 | gpu_reg1 | gpu_reg2 | gpu_reg3, 32'h0);
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead, input int b_stall);
    int         cyc;
    int         aw_start;
    int         w_start;
    bit         aw_done, w_done, aw_fire, w_fire;
    logic [1:0] idx;
    logic [1:0] exp_b;
    idx      = addr[3:2];
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    b_q.push_back(2'b00);
    pulse_cnt    = 0;
    pulse_seen   = 4'b0;
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    cyc = 0; aw_done = 1'b0; w_done = 1'b0;
    while (!(aw_done && w_done) && cyc < 60) begin
      s_axi_awvalid = !aw_done && (cyc >= aw_start);
      s_axi_wvalid  = !w_done && (cyc >= w_start);
      chk_eq("b_early", 32'(s_axi_bvalid), 32'h0);
      aw_fire = s_axi_awvalid && s_axi_awready;
      w_fire  = s_axi_wvalid && s_axi_wready;
      @(negedge clk);
      cyc++;
      if (aw_fire) aw_done = 1'b1;
      if (w_fire)  w_done  = 1'b1;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    chk_eq("wr_accept", 32'({aw_done, w_done}), 32'h3);
    chk_eq("b_latency", 32'(s_axi_bvalid), 32'h1);
    for (int i = 0; i < b_stall; i++) begin
      chk_eq("bstall_bvalid",  32'(s_axi_bvalid),  32'h1);
      chk_eq("bstall_awready", 32'(s_axi_awready), 32'h0);
      chk_eq("bstall_wready",  32'(s_axi_wready),  32'h0);
      @(negedge clk);
    end
    s_axi_bready = 1'b1;
    cyc = 0;
    while (!s_axi_bvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk_eq("bvalid_seen", 32'(s_axi_bvalid), 32'h1);
    exp_b = b_q.pop_front();
    chk_eq("bresp", 32'(s_axi_bresp), 32'(exp_b));
    @(negedge clk);
    s_axi_bready = 1'b0;
    chk_eq("bvalid_drop", 32'(s_axi_bvalid), 32'h0);
    chk_eq("wr_pulse_cnt", 32'(pulse_cnt), 32'h1);
    chk_eq("wr_pulse_idx", 32'(pulse_seen), 32'(4'b0001 << idx));
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, input int r_stall);
    int          cyc;
    logic [31:0] exp_d;
    r_q.push_back(model[addr[3:2]]);
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    cyc = 0;
    while (!s_axi_arready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk_eq("ar_ready", 32'(s_axi_arready), 32'h1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    chk_eq("r_latency", 32'(s_axi_rvalid), 32'h1);
    for (int i = 0; i < r_stall; i++) begin
      chk_eq("rstall_rvalid",  32'(s_axi_rvalid),  32'h1);
      chk_eq("rstall_rdata",   s_axi_rdata,        r_q[0]);
      chk_eq("rstall_arready", 32'(s_axi_arready), 32'h0);
      @(negedge clk);
    end
    s_axi_rready = 1'b1;
    exp_d = r_q.pop_front();
    chk_eq("rdata", s_axi_rdata, exp_d);
    chk_eq("rresp", 32'(s_axi_rresp), 32'h0);
    @(negedge clk);
    s_axi_rready = 1'b0;
    chk_eq("rvalid_drop", 32'(s_axi_rvalid), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    s_axi_awaddr = 4'h0; s_axi_awprot = 3'b000; s_axi_awvalid = 1'b0;
    s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = 4'h0; s_axi_arprot = 3'b000; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("idle_ready", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);

    // Basic write of each register, then read back.
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);
    chk_eq("gpu_reg0", gpu_reg0, 32'h1);
    chk_eq("gpu_reg1", gpu_reg1, 32'h2);
    chk_eq("gpu_reg2", gpu_reg2, 32'h3);
    chk_eq("gpu_reg3", gpu_reg3, 32'h4);

    // Zero strobe completes without changing the register; low address bits ignored.
    axi_write(4'h3, 32'hFFFF_FFFF, 4'h0, 0, 0);
    axi_read(4'h1, 0);

    // Split address/data ordering.
    axi_write(4'hC, 32'h0000_00C4, 4'hF, 3, 0);
    axi_write(4'h0, 32'h0000_00A0, 4'hF, -3, 0);
    axi_read(4'hC, 0);
    axi_read(4'h0, 0);

    // Partial byte strobes.
    axi_write(4'h4, 32'hAABB_CCDD, 4'hF, 0, 0);
    axi_write(4'h4, 32'h1122_3344, 4'h5, 0, 0);
    axi_read(4'h4, 0);
    chk_eq("strb_merge", gpu_reg1, 32'hAA22_CC44);

    // Back-pressure on both response channels.
    axi_write(4'hC, 32'hDEAD_BEEF, 4'hF, 0, 10);
    axi_read(4'hC, 10);

    // Same-edge read and write to register 2 (currently 0x3).
    fork
      axi_write(4'h8, 32'h0000_0055, 4'hF, 0, 0);
      axi_read(4'h8, 0);
    join
    axi_read(4'h8, 0);
    chk_eq("gpu_reg2_new", gpu_reg2, 32'h55);

    // Reset while holding an address, then recovery.
    s_axi_awaddr  = 4'h4;
    s_axi_awvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    chk_eq("have_a_awready", 32'(s_axi_awready), 32'h0);
    chk_eq("have_a_wready",  32'(s_axi_wready),  32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("rel_ready", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);
    chk_eq("rel_bvalid", 32'(s_axi_bvalid), 32'h0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);
    axi_write(4'hC, 32'h0000_0077, 4'hF, 0, 0);
    axi_read(4'hC, 0);

    chk_eq("b_q_empty", 32'(b_q.size()), 32'h0);
    chk_eq("r_q_empty", 32'(r_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
